// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module mult_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d, dbz_q, dbz_d;
    logic               is_signed, is_div;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;

    assign is_signed   = ~op_q[0];
    assign is_div      = op_q[1];
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Shared datapath: magnitudes, one shift-add or shift-subtract step, and sign fix-up
    always_comb begin
        abs_a    = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b    = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b0, b_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Sequencer next state: IDLE -> PREP -> CALC (ITER steps) -> FIX -> IDLE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = PREP;
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            PREP: begin
                neg_d   = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d  = is_signed & a_q[WIDTH-1];
                acc_d   = {{WIDTH{1'b0}}, abs_a};
                b_d     = abs_b;
                cnt_d   = CW'(ITER - 1);
                state_d = CALC;
            end
            CALC: begin
                acc_d   = !is_div ? {mul_sum, acc_q[WIDTH-1:1]} :
                          div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0} :
                          {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            default: begin
                dbz_d   = is_div && (b_q == '0);
                hi_d    = dbz_d ? hi_q : is_div ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = dbz_d ? lo_q : is_div ? quo : prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: scoreboard bench with an arithmetic reference model for HI/LO
module tb_mult_div_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        z;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    int          run = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    always #5 clk = ~clk;

    mult_div_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Reference model: plain 64-bit arithmetic; SV / and % truncate toward zero
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      q, r;
        ent_t        e;
        e.z = 1'b0;
        if (o == 2'b00) begin
            p = longint'($signed(x)) * longint'($signed(y));
            mhi = p[63:32]; mlo = p[31:0];
        end else if (o == 2'b01) begin
            p = {32'b0, x} * {32'b0, y};
            mhi = p[63:32]; mlo = p[31:0];
        end else if (y == 0) begin
            e.z = 1'b1;
        end else if (o == 2'b10) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            mlo = q[31:0]; mhi = r[31:0];
        end else begin
            mlo = x / y; mhi = x % y;
        end
        e.h = mhi;
        e.l = mlo;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", {63'b0, busy}, 64'd0);
        start = 1'b1; op = o; a = x; b = y;
        model(o, x, y);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        hi_we = hw; lo_we = lw; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) mhi = d;
        if (lw) mlo = d;
        chk("mt_hi", {32'b0, hi}, {32'b0, mhi});
        chk("mt_lo", {32'b0, lo}, {32'b0, mlo});
    endtask

    // Monitor: pops the scoreboard on every done pulse and times the busy window
    always @(negedge clk) begin
        if (reset) run = 0;
        else begin
            if (busy) run++;
            if (done) begin
                chk("busy_len", 64'(run), 64'd34);
                run = 0;
                chk("done_expected", {63'b0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("hi", {32'b0, hi}, {32'b0, mon_e.h});
                    chk("lo", {32'b0, lo}, {32'b0, mon_e.l});
                    chk("dbz", {63'b0, div_by_zero}, {63'b0, mon_e.z});
                    chk("busy_in_done", {63'b0, busy}, 64'd0);
                end
            end else chk("dbz_idle", {63'b0, div_by_zero}, 64'd0);
        end
    end

    initial begin
        logic [31:0] sh, sl, x, y;
        logic [1:0]  o;
        int          n;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        drain();
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        issue(2'b00, 32'd7, 32'd6);
        drain();
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        drain();
        mt(1'b1, 1'b0, 32'h1234);
        mt(1'b0, 1'b1, 32'h5678);
        issue(2'b11, 32'd9, 32'd0);
        drain();
        mt(1'b1, 1'b1, $urandom);
        sh = mhi; sl = mlo;
        issue(2'b01, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 32'd11; b = 32'd13; op = 2'b00; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_mid", {63'b0, busy}, 64'd1);
        chk("hold_hi", {32'b0, hi}, {32'b0, sh});
        chk("hold_lo", {32'b0, lo}, {32'b0, sl});
        drain();
        issue(2'b11, 32'd50, 32'd5);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        mhi = '0; mlo = '0;
        @(negedge clk);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'b11, 32'd50, 32'd5);
        drain();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) begin
                drain();
                mt(1'($urandom), 1'($urandom), $urandom);
            end
            o = 2'($urandom);
            n = int'($urandom_range(7));
            y = (n == 0) ? 32'd0 : (n == 1) ? 32'hFFFFFFFF : (n == 2) ? 32'd1 : $urandom;
            x = ($urandom_range(5) == 0) ? 32'h80000000 : $urandom;
            issue(o, x, y);
        end
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
